muldiv: RTL and testbench

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv.sv | 94 +++++++++
 tb/tb_muldiv.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// muldiv: iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
//   clk, rst        : clock, synchronous active-high reset
//   A, B, op        : operands and operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   start, flush    : begin an operation / cancel any in-flight or requested one
//   mthi, mtlo      : write A into hi / lo when not busy
//   hi, lo          : result registers
//   busy, done, dz  : running, one-cycle completion pulse, last division by zero
module muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        flush,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        dz
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_p;
  logic [31:0] r_m;
  logic        r_div, r_neg_q, r_neg_r, r_bz;
  logic        w_acc;
  logic [31:0] w_abs_a, w_abs_b, w_quo, w_rem;
  logic [32:0] w_mul_sum, w_div_diff;
  logic [63:0] w_step, w_prod;
  assign busy = r_state == S_RUN;
  assign done = r_state == S_DONE;
  // r_p holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    w_acc      = start & ~flush & ~busy;
    w_abs_a    = (~op[0] & A[31]) ? -A : A;
    w_abs_b    = (~op[0] & B[31]) ? -B : B;
    w_mul_sum  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_m} : 33'd0);
    // remainder < divisor, so bit 32 of the trial difference is the borrow
    w_div_diff = r_p[63:31] - {1'b0, r_m};
    w_step     = r_div ? (w_div_diff[32] ? {r_p[62:0], 1'b0} : {w_div_diff[31:0], r_p[30:0], 1'b1})
                       : {w_mul_sum, r_p[31:1]};
    w_prod     = r_neg_q ? -w_step : w_step;
    w_quo      = r_neg_q ? -w_step[31:0] : w_step[31:0];
    w_rem      = r_neg_r ? -w_step[63:32] : w_step[63:32];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_p     <= 64'd0;
      r_m     <= 32'd0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      dz      <= 1'b0;
    end else begin
      if (~busy & mthi) hi <= A;
      if (~busy & mtlo) lo <= A;
      if (flush) r_state <= S_IDLE;
      else if (w_acc) begin
        r_state <= S_RUN;
        r_cnt   <= 5'd0;
        dz      <= 1'b0;
        r_div   <= op[1];
        r_neg_q <= ~op[0] & (A[31] ^ B[31]);
        r_neg_r <= ~op[0] & A[31];
        r_bz    <= B == 32'd0;
        r_m     <= w_abs_b;
        r_p     <= {32'd0, w_abs_a};
      end else if (busy) begin
        r_cnt <= r_cnt + 5'd1;
        r_p   <= w_step;
        if (r_cnt == 5'd31) begin
          r_state <= S_DONE;
          dz      <= r_div & r_bz;
          // divide by zero runs the full length but leaves hi/lo untouched
          if (~(r_div & r_bz)) begin
            hi <= r_div ? w_rem : w_prod[63:32];
            lo <= r_div ? w_quo : w_prod[31:0];
          end
        end
      end else r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: scoreboard bench for muldiv with directed vectors
module tb_muldiv;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [1:0]  op = '0;
  logic        start = 1'b0, flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, dz;
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz; string name;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  muldiv dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .op(op), .start(start), .flush(flush),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input string name);
    A = a; B = b; op = o; start = 1'b1;
    if (push) q.push_back('{hi: eh, lo: el, dz: edz, name: name});
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom);
  endtask
  task automatic wait_done(input string name, input int n0);
    int n = n0;
    while (done !== 1'b1 && n < 40) begin
      chk({name, "_busy"}, {63'd0, busy}, 64'd1);
      tick();
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'd33);
    chk({name, "_busy_in_done"}, {63'd0, busy}, 64'd0);
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: hi=%h lo=%h dz=%b with no operation expected", hi, lo, dz);
      end else begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (hi !== e.hi || lo !== e.lo || dz !== e.dz) begin
          bad++;
          $display("FAIL %s: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                   e.name, hi, lo, dz, e.hi, e.lo, e.dz);
        end
      end
    end
  end
  initial begin
    logic seen_done;
    tick(); tick();
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, dz}, 64'd0);
    rst = 1'b0;
    tick();
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0, "multu_max");
    wait_done("multu_max", 1);
    tick();
    issue(2'b00, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, "mult_neg");
    wait_done("mult_neg", 1);
    tick();
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, "div_neg");
    wait_done("div_neg", 1);
    tick();
    issue(2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, "divu_100_7");
    wait_done("divu_100_7", 1);
    tick();
    issue(2'b11, 32'd5, 32'd0, 1, 32'd2, 32'd14, 1, "divu_by_zero");
    wait_done("divu_by_zero", 1);
    tick();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 32'h80000000, 0, "div_overflow");
    chk("dz_clear_on_start", {63'd0, dz}, 64'd0);
    wait_done("div_overflow", 1);
    tick();
    issue(2'b01, 32'd3, 32'd4, 0, 32'd0, 32'd0, 0, "flushed");
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    seen_done = 1'b0;
    repeat (30) begin
      seen_done |= done;
      tick();
    end
    chk("flush_no_done", {63'd0, seen_done}, 64'd0);
    chk("flush_hilo", {hi, lo}, {32'd0, 32'h80000000});
    start = 1'b1; flush = 1'b1; A = 32'd9; B = 32'd9; op = 2'b01;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("start_flush_idle", {62'd0, busy, done}, 64'd0);
    issue(2'b01, 32'd2, 32'd3, 1, 32'd0, 32'd6, 0, "multu_2_3");
    A = 32'h12345678; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    chk("mtlo_busy_ignored", {32'd0, lo}, 64'h80000000);
    wait_done("multu_2_3", 2);
    issue(2'b01, 32'd7, 32'd8, 1, 32'd0, 32'd56, 0, "b2b_multu");
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done("b2b_multu", 1);
    tick();
    A = 32'h12345678; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    chk("mtlo_idle", {32'd0, lo}, 64'h12345678);
    A = 32'hCAFEBABE; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    chk("mthi_idle", {32'd0, hi}, 64'hCAFEBABE);
    issue(2'b01, 32'd11, 32'd13, 0, 32'd0, 32'd0, 0, "reset_abort");
    repeat (19) tick();
    rst = 1'b1;
    tick();
    chk("midrun_rst_hilo", {hi, lo}, 64'd0);
    chk("midrun_rst_flags", {61'd0, busy, done, dz}, 64'd0);
    rst = 1'b0;
    tick();
    issue(2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, "after_rst_divu");
    wait_done("after_rst_divu", 1);
    repeat (3) tick();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
